posit_alu: RTL and testbench
============================

# posit_alu

8-bit posit arithmetic unit (posit<8,0>, es = 0) for the datapath's posit execution stage. Two posit operands and a 3-bit opcode produce one registered posit result per clock. Operations: add, subtract, multiply, min and max, all with posit rounding and NaR semantics. Fully pipelined: a new operation can be issued every cycle.

## Interface
- Parameters: none; widths are fixed (N = 8, ES = 0) via package constants.
- `clk  in  1`  rising-edge clock.
- `rst_n  in  1`  reset, asynchronous, active-low.
- `in_valid  in  1`  operands/select valid this cycle.
- `positnum1  in  8`  operand A, posit<8,0>.
- `positnum2  in  8`  operand B, posit<8,0>.
- `select  in  3`  opcode: 000 add, 001 sub (A−B), 010 mul, 011 min, 100 max, 101–111 reserved.
- `positoutput  out  8`  registered result.
- `out_valid  out  1`  `positoutput` holds the result of an accepted operation.

## Operation
- **Decode.** Sign is bit 7. Negative values are decoded from the two's complement of the word. Regime gives scale k with useed = 2. The remaining bits form the fraction with hidden 1.
- **Special values.**
  - 0x00 is zero.
  - 0x80 is NaR.
  - Any NaR operand yields NaR for add, sub and mul.
  - Zero is exact: x+0 = x, x·0 = 0.
  - x − x = 0x00, never −0.
- **Add/sub.** Sub negates B (two's complement of the word), then adds. Align on scale, add or subtract magnitudes with guard and sticky bits, normalise, re-encode.
- **Mul.** Sign is the XOR of the operand signs. Scale is the sum of the operand scales. Multiply the 6-bit significands, normalise.
- **Rounding.**
  - Round to nearest, ties to even, applied on the encoded bit pattern.
  - Magnitudes above maxpos saturate to 0x7F / 0x81.
  - Nonzero magnitudes below minpos round to 0x01 / 0xFF, never to zero or NaR.
- **Min/max.**
  - Compare the words as signed 8-bit integers.
  - NaR (0x80) is the smallest value, so min(NaR, x) = NaR and max(NaR, x) = x.
- **Reserved opcodes** (101–111) produce 0x00.

## Timing
- Combinational compute followed by an output register; latency is 1 cycle.
- On the rising edge where `in_valid` = 1, `positoutput` takes the result and `out_valid` goes to 1.
- On a rising edge where `in_valid` = 0, `out_valid` goes to 0 and `positoutput` holds its value.
- Throughput is one operation per cycle. Back-to-back operations are independent. There is no backpressure.
- Reset (asynchronous assert): `positoutput` = 0x00 and `out_valid` = 0 immediately.
- Reset release is synchronous to `clk`. The first accepted operation after release is the first valid output.
- An operation in flight when reset asserts is discarded.

## Configuration
- Macro `POSIT_ALU_MUL_EN`.
- Defined: opcode 010 performs multiply as specified.
- Undefined: no multiplier is built, and opcode 010 returns NaR (0x80) with normal latency and `out_valid`.

## Structure
- Package `posit_pkg` holds:
  - constants N = 8, ES = 0;
  - NAR = 8'h80, MAXPOS = 8'h7F, MINPOS = 8'h01;
  - an opcode enum typedef (OP_ADD, OP_SUB, OP_MUL, OP_MIN, OP_MAX);
  - the decoded-posit struct (sign, is_zero, is_nar, signed scale, fraction).
- Sub-module `posit_decode` (word → decoded struct) is instantiated twice, once per operand.
- Encode/round logic stays inside `alu`.

## Test plan
- Reset: assert `rst_n` = 0 mid-operation → `positoutput` = 0x00 and `out_valid` = 0 without a clock edge.
- Add: 0x40+0x40 → 0x60 (1+1 = 2). Mixed sign: 0x59+0xCA → 0x3C (1.78125 − 0.84375 = 0.9375). Each appears one cycle after issue with `out_valid` = 1.
- Sub and mul:
  - 0x50−0x40 → 0x20 (0.5);
  - 0x40−0x40 → 0x00;
  - 0x50×0x50 → 0x62 (2.25);
  - without `POSIT_ALU_MUL_EN`, 0x50×0x50 → 0x80.
- Saturation and NaR:
  - 0x7F+0x7F → 0x7F;
  - 0x01×0x01 → 0x01;
  - 0x80+0x40 → 0x80;
  - 0x80−0x80 → 0x80.
- Min/max and reserved:
  - min(0xC0, 0x40) → 0xC0;
  - max(0xC0, 0x40) → 0x40;
  - max(0x80, 0x01) → 0x01;
  - select 111 → 0x00.
- Streaming: issue opcodes 000–100 on consecutive cycles with A = 0x59, B = 0xCA → results emerge in order with 1-cycle latency. A bubble (`in_valid` = 0) drops `out_valid` and holds the last result.

Source files
------------

// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_pkg
// Description : Shared constants, opcode encoding and decoded-posit record
//               for the posit<8,0> arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

    localparam int N  = 8;
    localparam int ES = 0;

    localparam logic [7:0] NAR    = 8'h80;
    localparam logic [7:0] MAXPOS = 8'h7F;
    localparam logic [7:0] MINPOS = 8'h01;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_MIN = 3'b011,
        OP_MAX = 3'b100
    } opcode_t;

    // Value = (-1)^sign * 2^scale * 1.frac
    typedef struct packed {
        logic              sign;
        logic              is_zero;
        logic              is_nar;
        logic signed [4:0] scale;
        logic [4:0]        frac;
    } posit_t;

endpackage
`default_nettype wire

// File: rtl/posit_alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : posit_decode
// Description : Unpacks a posit<8,0> word into sign, scale and fraction.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_decode
    import posit_pkg::*;
(
    input  logic [7:0] i_word,
    output posit_t     o_dec
);

    logic [6:0] w_mag;
    logic       w_r0;
    logic [3:0] w_run;
    logic       w_done;

    always_comb begin
        w_mag  = i_word[7] ? 7'(8'd0 - i_word) : i_word[6:0];
        w_r0   = w_mag[6];
        w_run  = 4'd0;
        w_done = 1'b0;
        // Regime run length, counted from the bit after the sign
        for (int i = 6; i >= 0; i--) begin
            if (!w_done) begin
                if (w_mag[i] == w_r0) w_run = w_run + 4'd1;
                else                  w_done = 1'b1;
            end
        end

        o_dec.sign    = i_word[7];
        o_dec.is_zero = (i_word == 8'h00);
        o_dec.is_nar  = (i_word == NAR);
        o_dec.scale   = w_r0 ? ($signed({1'b0, w_run}) - 5'sd1)
                             : (5'sd0 - $signed({1'b0, w_run}));
        o_dec.frac    = 5'((w_mag << (w_run + 4'd1)) >> 2);
    end

endmodule
`default_nettype wire

// File: rtl/posit_alu.sv
`default_nettype none
// ============================================================================
// Module      : posit_alu
// Description : posit<8,0> add/sub/mul/min/max with one-cycle registered
//               result. Multiplier present only when POSIT_ALU_MUL_EN is
//               defined; otherwise opcode 010 returns NaR.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_alu
    import posit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] positnum1,
    input  logic [7:0] positnum2,
    input  logic [2:0] select,
    output logic [7:0] positoutput,
    output logic       out_valid
);

    // Builds regime+fraction as one bit string, then rounds the 7-bit body
    // to nearest-even with saturation at maxpos and minpos.
    function automatic logic [7:0] round_encode(input logic              sign,
                                                input logic signed [6:0] scale,
                                                input logic [17:0]       frac);
        logic signed [27:0] base;
        logic signed [27:0] sh;
        logic [2:0]         amt;
        logic [7:0]         body;
        logic [6:0]         mag;
        logic               guard;
        logic               sticky;
        if (scale > 7'sd6) begin
            mag = MAXPOS[6:0];
        end else if (scale < -7'sd6) begin
            mag = MINPOS[6:0];
        end else begin
            if (scale >= 7'sd0) begin
                base = {2'b10, frac, 8'b0};
                amt  = 3'(scale);
            end else begin
                base = {2'b01, frac, 8'b0};
                amt  = 3'(~scale);
            end
            sh     = base >>> amt;
            guard  = sh[20];
            sticky = |sh[19:0];
            body   = {1'b0, sh[27:21]} + {7'd0, guard & (sticky | sh[21])};
            mag    = body[7] ? MAXPOS[6:0]
                   : ((body[6:0] == 7'd0) ? MINPOS[6:0] : body[6:0]);
        end
        return sign ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

    opcode_t     w_op;
    logic [7:0]  w_bword;
    posit_t      w_a;
    posit_t      w_b;

    assign w_op    = opcode_t'(select);
    assign w_bword = (w_op == OP_SUB) ? (8'd0 - positnum2) : positnum2;

    posit_decode u_dec_a (.i_word(positnum1), .o_dec(w_a));
    posit_decode u_dec_b (.i_word(w_bword),   .o_dec(w_b));

    posit_t            w_big;
    posit_t            w_small;
    logic [4:0]        w_diff;
    logic [18:0]       w_big_sig;
    logic [18:0]       w_small_sig;
    logic [18:0]       w_sum;
    logic [4:0]        w_lead;
    logic [17:0]       w_add_frac;
    logic signed [6:0] w_add_scale;
    logic [7:0]        w_add_res;

    always_comb begin
        if (($signed(w_a.scale) > $signed(w_b.scale)) ||
            ((w_a.scale == w_b.scale) && (w_a.frac >= w_b.frac))) begin
            w_big   = w_a;
            w_small = w_b;
        end else begin
            w_big   = w_b;
            w_small = w_a;
        end
        // 12 spare low bits cover the widest scale gap, so alignment is exact
        w_diff      = 5'($signed(w_big.scale) - $signed(w_small.scale));
        w_big_sig   = {2'b01, w_big.frac, 12'b0};
        w_small_sig = {2'b01, w_small.frac, 12'b0} >> w_diff;
        w_sum       = (w_big.sign != w_small.sign) ? (w_big_sig - w_small_sig)
                                                   : (w_big_sig + w_small_sig);
        w_lead = 5'd0;
        for (int i = 0; i < 19; i++) begin
            if (w_sum[i]) w_lead = 5'(i);
        end
        w_add_frac  = 18'(w_sum << (5'd18 - w_lead));
        w_add_scale = 7'($signed(w_big.scale)) + $signed(7'(w_lead)) - 7'sd17;

        if (w_a.is_nar || w_b.is_nar) w_add_res = NAR;
        else if (w_a.is_zero)         w_add_res = w_bword;
        else if (w_b.is_zero)         w_add_res = positnum1;
        else if (w_sum == 19'd0)      w_add_res = 8'h00;
        else w_add_res = round_encode(w_big.sign, w_add_scale, w_add_frac);
    end

    logic [7:0] w_mul_res;

`ifdef POSIT_ALU_MUL_EN
    logic [11:0]       w_prod;
    logic [17:0]       w_mul_frac;
    logic signed [6:0] w_mul_scale;

    always_comb begin
        w_prod = {6'd0, 1'b1, w_a.frac} * {6'd0, 1'b1, w_b.frac};
        if (w_prod[11]) begin
            w_mul_frac  = {w_prod[10:0], 7'b0};
            w_mul_scale = 7'($signed(w_a.scale)) + 7'($signed(w_b.scale)) + 7'sd1;
        end else begin
            w_mul_frac  = {w_prod[9:0], 8'b0};
            w_mul_scale = 7'($signed(w_a.scale)) + 7'($signed(w_b.scale));
        end
        if (w_a.is_nar || w_b.is_nar)        w_mul_res = NAR;
        else if (w_a.is_zero || w_b.is_zero) w_mul_res = 8'h00;
        else w_mul_res = round_encode(w_a.sign ^ w_b.sign, w_mul_scale, w_mul_frac);
    end
`else
    assign w_mul_res = NAR;
`endif

    logic [7:0] w_result;

    // NaR is 0x80, the most negative signed byte, so plain signed compare orders it first
    always_comb begin
        case (w_op)
            OP_ADD, OP_SUB: w_result = w_add_res;
            OP_MUL:         w_result = w_mul_res;
            OP_MIN:         w_result = ($signed(positnum1) < $signed(positnum2)) ? positnum1 : positnum2;
            OP_MAX:         w_result = ($signed(positnum1) < $signed(positnum2)) ? positnum2 : positnum1;
            default:        w_result = 8'h00;
        endcase
    end

    logic [7:0] r_result;
    logic       r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 8'h00;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_result <= w_result;
        end
    end

    assign positoutput = r_result;
    assign out_valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_posit_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_posit_alu
// Description : Directed self-checking bench for posit_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] positnum1;
    logic [7:0] positnum2;
    logic [2:0] select;
    logic [7:0] positoutput;
    logic       out_valid;

    int n_checks = 0;
    int n_errors = 0;

`ifdef POSIT_ALU_MUL_EN
    localparam logic [7:0] c_mul_1p5_sq  = 8'h62;
    localparam logic [7:0] c_mul_minpos  = 8'h01;
    localparam logic [7:0] c_mul_stream  = 8'hB0;
`else
    localparam logic [7:0] c_mul_1p5_sq  = 8'h80;
    localparam logic [7:0] c_mul_minpos  = 8'h80;
    localparam logic [7:0] c_mul_stream  = 8'h80;
`endif

    posit_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .positnum1   (positnum1),
        .positnum2   (positnum2),
        .select      (select),
        .positoutput (positoutput),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sel, input logic [7:0] exp);
        @(negedge clk);
        in_valid  = 1'b1;
        positnum1 = a;
        positnum2 = b;
        select    = sel;
        @(posedge clk);
        #1;
        check(tag, positoutput, exp);
        check({tag, "_vld"}, {7'd0, out_valid}, 8'd1);
    endtask

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        positnum1 = 8'h00;
        positnum2 = 8'h00;
        select    = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", positoutput, 8'h00);
        check("rst_vld", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_vld", {7'd0, out_valid}, 8'd0);

        vecs.push_back('{"add_1p1",    8'h40, 8'h40, 3'b000, 8'h60});
        vecs.push_back('{"add_mixed",  8'h59, 8'hCA, 3'b000, 8'h3C});
        vecs.push_back('{"sub_half",   8'h50, 8'h40, 3'b001, 8'h20});
        vecs.push_back('{"sub_self",   8'h40, 8'h40, 3'b001, 8'h00});
        vecs.push_back('{"sub_neg",    8'h40, 8'h50, 3'b001, 8'hE0});
        vecs.push_back('{"mul_1p5",    8'h50, 8'h50, 3'b010, c_mul_1p5_sq});
        vecs.push_back('{"add_sat",    8'h7F, 8'h7F, 3'b000, 8'h7F});
        vecs.push_back('{"mul_minpos", 8'h01, 8'h01, 3'b010, c_mul_minpos});
        vecs.push_back('{"add_nar",    8'h80, 8'h40, 3'b000, 8'h80});
        vecs.push_back('{"sub_nar",    8'h80, 8'h80, 3'b001, 8'h80});
        vecs.push_back('{"add_zero",   8'hCA, 8'h00, 3'b000, 8'hCA});
        vecs.push_back('{"min",        8'hC0, 8'h40, 3'b011, 8'hC0});
        vecs.push_back('{"max",        8'hC0, 8'h40, 3'b100, 8'h40});
        vecs.push_back('{"max_nar",    8'h80, 8'h01, 3'b100, 8'h01});
        vecs.push_back('{"min_nar",    8'h80, 8'h01, 3'b011, 8'h80});
        vecs.push_back('{"reserved",   8'h59, 8'hCA, 3'b111, 8'h00});
        foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp);

        // Back-to-back stream, A = 1.78125, B = -0.84375
        run_op("str_add", 8'h59, 8'hCA, 3'b000, 8'h3C);
        run_op("str_sub", 8'h59, 8'hCA, 3'b001, 8'h65);
        run_op("str_mul", 8'h59, 8'hCA, 3'b010, c_mul_stream);
        run_op("str_min", 8'h59, 8'hCA, 3'b011, 8'hCA);
        run_op("str_max", 8'h59, 8'hCA, 3'b100, 8'h59);

        @(negedge clk);
        in_valid  = 1'b0;
        positnum1 = 8'h40;
        positnum2 = 8'h40;
        select    = 3'b000;
        @(posedge clk);
        #1;
        check("bubble_vld",  {7'd0, out_valid}, 8'd0);
        check("bubble_hold", positoutput, 8'h59);

        // Asynchronous reset while an operation is presented
        @(negedge clk);
        in_valid  = 1'b1;
        positnum1 = 8'h40;
        positnum2 = 8'h40;
        select    = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", positoutput, 8'h00);
        check("async_rst_vld", {7'd0, out_valid}, 8'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_vld", {7'd0, out_valid}, 8'd0);
        run_op("post_rst_add", 8'h40, 8'h40, 3'b000, 8'h60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
